// File: rtl/seq_alu_pkg.sv
// Purpose: opcodes, FSM encoding and opcode helpers shared by seq_alu and the ALU control decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_alu_pkg;

  // 4-bit ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;  // also BEQ
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_DIVU = 4'b1010;
  localparam logic [3:0] ALU_REMU = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b1101;
  localparam logic [3:0] ALU_BNE  = 4'b1110;  // SUB with inverted zero flag
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ITER = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  // Operations that run through the one-bit-per-clock datapath
  function automatic logic is_iterative(input logic [3:0] ctrl);
    return (ctrl == ALU_MUL) || (ctrl == ALU_DIVU) || (ctrl == ALU_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Purpose: shift-add multiplier / restoring unsigned divider, one bit per enabled clock.
// Latency: WIDTH enabled steps after load; final values visible on the *_nxt outputs during the last step.
// Backpressure: none; stepping is fully controlled by step_i from the owning FSM.
// Ports: load_i/mode_div_i/op_a_i/op_b_i latch a new operation; step_i advances one bit;
//        acc_nxt_o = product (MUL) or remainder (DIV), quo_nxt_o = quotient, both as they
//        will be after the current step.
module seq_alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             mode_div_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] acc_nxt_o,
  output logic [WIDTH-1:0] quo_nxt_o
);

  // acc_q: running product or partial remainder
  // sh_q : multiplicand (shifts left) or dividend/quotient (shifts left, quotient bits enter at LSB)
  // opb_q: multiplier (shifts right) or divisor (constant)
  logic             mode_div_q;
  logic [WIDTH-1:0] acc_q, sh_q, opb_q;
  logic [WIDTH-1:0] acc_d, sh_d, opb_d;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             rem_ge;

  // Restoring step: bring the next dividend bit into the remainder, subtract the divisor,
  // keep the difference only if it did not borrow. A zero divisor never borrows, which
  // naturally yields an all-ones quotient and the dividend as remainder.
  assign rem_sh   = {acc_q, sh_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign rem_ge   = ~rem_diff[WIDTH];

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    opb_d = opb_q;
    if (mode_div_q) begin
      acc_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], rem_ge};
    end else begin
      acc_d = acc_q + (opb_q[0] ? sh_q : '0);
      sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      opb_d = {1'b0, opb_q[WIDTH-1:1]};
    end
  end

  assign acc_nxt_o = acc_d;
  assign quo_nxt_o = sh_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mode_div_q <= 1'b0;
      acc_q      <= '0;
      sh_q       <= '0;
      opb_q      <= '0;
    end else if (load_i) begin
      mode_div_q <= mode_div_i;
      acc_q      <= '0;
      sh_q       <= op_a_i;
      opb_q      <= op_b_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Purpose: registered multi-cycle ALU with start/busy/done handshake (WIDTH even, >= 8).
// Latency: single-cycle ops done 1 clock after start; MUL/DIVU/REMU done WIDTH+1 clocks after start.
// Backpressure: start_i is ignored (not queued) while busy_o=1; no output stall.
// Ports: clk_i/rst_i clock and async active-low reset; start_i/ctrl_i/src1_i/src2_i request;
//        busy_o iteration in progress; done_o one-cycle valid pulse for result_o/zero_o/overflow_o,
//        which hold their values until the next done_o.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic             done_q, zero_q, ovf_q;
  logic [WIDTH-1:0] result_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_ovf;
  logic             accept, accept_iter;
  logic [WIDTH-1:0] acc_nxt, quo_nxt, iter_res;

  // ---------------- single-cycle datapath ----------------
  assign shamt = src1_i[SHW-1:0];
  assign sum   = src1_i + src2_i;
  assign dif   = src1_i - src2_i;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl_i)
      ALU_AND:  alu_res = src1_i & src2_i;
      ALU_OR:   alu_res = src1_i | src2_i;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SLL:  alu_res = src2_i << shamt;
      ALU_LUI:  alu_res = {src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SUB, ALU_BNE: begin
        alu_res = dif;
        alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (dif[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      ALU_SRL:  alu_res = src2_i >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt);
      ALU_XOR:  alu_res = src1_i ^ src2_i;
      ALU_NOR:  alu_res = ~(src1_i | src2_i);
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
      default:  alu_res = '0;  // iterative codes are handled by seq_alu_iter
    endcase
    // BNE reports "not equal" on the zero flag
    alu_zero = (alu_res == '0) ^ (ctrl_i == ALU_BNE);
  end

  // ---------------- iterative datapath ----------------
  // FIN behaves like IDLE for new requests since busy_o is already low there.
  assign accept      = start_i && (state_q != ST_ITER);
  assign accept_iter = accept && is_iterative(ctrl_i);

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept_iter),
    .mode_div_i (ctrl_i != ALU_MUL),
    .op_a_i     (src1_i),
    .op_b_i     (src2_i),
    .step_i     (state_q == ST_ITER),
    .acc_nxt_o  (acc_nxt),
    .quo_nxt_o  (quo_nxt)
  );

  // The last step's outcome is captured directly from the next-value outputs so the
  // result is already registered when FIN presents done_o.
  assign iter_res = (op_q == ALU_DIVU) ? quo_nxt : acc_nxt;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= ALU_AND;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_ITER) begin
        cnt_q <= cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_q  <= ST_FIN;
          done_q   <= 1'b1;
          result_q <= iter_res;
          zero_q   <= (iter_res == '0);
          ovf_q    <= 1'b0;
        end
      end else begin
        state_q <= ST_IDLE;
        if (accept_iter) begin
          state_q <= ST_ITER;
          cnt_q   <= '0;
          op_q    <= ctrl_i;
        end else if (accept) begin
          done_q   <= 1'b1;
          result_q <= alu_res;
          zero_q   <= alu_zero;
          ovf_q    <= alu_ovf;
        end
      end
    end
  end

  assign busy_o     = (state_q == ST_ITER);
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         clk, rst, start;
  logic [3:0]   ctrl;
  logic [W-1:0] s1, s2;
  logic         busy_o, done_o, zero_o, overflow_o;
  logic [W-1:0] result_o;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .ctrl_i     (ctrl),
    .src1_i     (s1),
    .src2_i     (s2),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    int           due;
    int           idx;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } vec_t;

  localparam int NV = 21;
  vec_t vt[NV];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done_o pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst && done_o) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result#%0d", e.idx), result_o, e.res);
        chk($sformatf("zero#%0d", e.idx), {31'b0, zero_o}, {31'b0, e.z});
        chk($sformatf("ovf#%0d", e.idx), {31'b0, overflow_o}, {31'b0, e.ov});
        chk($sformatf("done_cycle#%0d", e.idx), 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge; applies start for one clock and records the expectation.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] r, input logic z, input logic ov,
                       input int idx);
    exp_t e;
    start = 1'b1;
    ctrl  = op;
    s1    = a;
    s2    = b;
    if (push) begin
      e.res = r;
      e.z   = z;
      e.ov  = ov;
      e.due = cyc + 1 + (is_iterative(op) ? W : 0);
      e.idx = idx;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d outstanding results expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic setv(input int i, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                      input logic ov);
    vt[i].op = op; vt[i].a = a; vt[i].b = b;
    vt[i].res = r; vt[i].z = z; vt[i].ov = ov;
  endtask

  initial begin
    // single-cycle ops first so they issue back-to-back
    setv(0,  ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    setv(1,  ALU_SUB,  32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0);
    setv(2,  ALU_BNE,  32'd5,        32'd5,        32'h00000000, 1'b0, 1'b0);
    setv(3,  ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    setv(4,  ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    setv(5,  ALU_SRA,  32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0);
    setv(6,  ALU_SRL,  32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0);
    setv(7,  ALU_AND,  32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0, 1'b0);
    setv(8,  ALU_OR,   32'h000000F0, 32'h0000003C, 32'h000000FC, 1'b0, 1'b0);
    setv(9,  ALU_LUI,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0);
    setv(10, ALU_XOR,  32'h000000F0, 32'h0000003C, 32'h000000CC, 1'b0, 1'b0);
    setv(11, ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    setv(12, ALU_SLL,  32'hFFFFFF24, 32'h00000001, 32'h00000010, 1'b0, 1'b0);
    setv(13, ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
    setv(14, ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    setv(15, ALU_MUL,  32'd7,        32'd6,        32'd42,       1'b0, 1'b0);
    setv(16, ALU_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
    setv(17, ALU_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
    setv(18, ALU_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0);
    setv(19, ALU_REMU, 32'd5,        32'd0,        32'd5,        1'b0, 1'b0);
    setv(20, ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);

    start = 1'b0; ctrl = 4'd0; s1 = '0; s2 = '0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'b0, busy_o},     32'd0);
    chk("rst_done",   {31'b0, done_o},     32'd0);
    chk("rst_result", result_o,            32'd0);
    chk("rst_zero",   {31'b0, zero_o},     32'd0);
    chk("rst_ovf",    {31'b0, overflow_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // table: single-cycle ops issue every cycle; iterative ones wait for completion
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, 1'b1, vt[i].res, vt[i].z, vt[i].ov, i);
      if (is_iterative(vt[i].op)) begin
        chk($sformatf("busy_after_start#%0d", i), {31'b0, busy_o}, 32'd1);
        wait_empty("table");
      end
    end
    wait_empty("table");

    // MUL with busy window check and ignored start pulses
    drive(ALU_MUL, 32'd7, 32'd6, 1'b1, 32'd42, 1'b0, 1'b0, 100);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("mul_busy_k%0d", k), {31'b0, busy_o}, 32'd1);
      if (k % 8 == 3) begin
        start = 1'b1; ctrl = ALU_ADD; s1 = 32'd1; s2 = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_fin", {31'b0, busy_o}, 32'd0);
    chk("mul_done_fin", {31'b0, done_o}, 32'd1);
    repeat (3) @(negedge clk);
    chk("mul_done_low", {31'b0, done_o}, 32'd0);
    chk("mul_hold",     result_o,        32'd42);
    wait_empty("mul");

    // reset in the middle of a MUL aborts it
    drive(ALU_MUL, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 1'b0, 200);
    repeat (9) @(negedge clk);
    chk("abort_busy_pre", {31'b0, busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy",   {31'b0, busy_o}, 32'd0);
    chk("abort_result", result_o,        32'd0);
    chk("abort_done",   {31'b0, done_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    drive(ALU_ADD, 32'd2, 32'd3, 1'b1, 32'd5, 1'b0, 1'b0, 300);
    wait_empty("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered, multi-cycle successor to the combinational 32-bit ALU in the single-cycle datapath.
- Serves the multi-cycle/pipelined CPU datapath.
- Adds a start/busy/done handshake, iterative multiply and unsigned divide/remainder, logical and arithmetic right shifts, XOR/NOR, and a signed-overflow flag.
- Single-cycle ops complete in one clock; MUL/DIVU/REMU iterate one bit per clock.

Parameters:
WIDTH, 32, operand/result width; must be even and at least 8
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  operation request; sampled only when busy_o=0
ctrl_i  input  4  operation code, sampled with start_i
src1_i  input  WIDTH  operand A; shift amount is src1_i[SHW-1:0]
src2_i  input  WIDTH  operand B
busy_o  output  1  iterative operation in progress
done_o  output  1  one-cycle pulse: result_o/zero_o/overflow_o are valid
result_o  output  WIDTH  registered result, held until the next done_o
zero_o  output  1  result_o==0; inverted for code 1110 (BNE)
overflow_o  output  1  signed overflow for ADD/SUB codes; 0 otherwise

Behaviour:
- Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0011 SLL (src2<<sh); 0100 LUI ({src2[WIDTH/2-1:0], WIDTH/2 zeros}); 0101 MUL (low WIDTH bits); 0110 SUB/BEQ; 0111 SLT signed; 1000 SRL; 1001 SRA; 1010 DIVU; 1011 REMU; 1100 XOR; 1101 NOR; 1110 SUB with inverted zero (BNE); 1111 SLTU.
- SLT/SLTU result is zero-extended 1/0.
- Reset (rst_i=0, async): state IDLE; busy_o=0, done_o=0, result_o=0, zero_o=0, overflow_o=0; iteration counter and working registers cleared.
- Reset asserted mid-iteration aborts the operation; no done_o is produced for it.
- FSM states: IDLE, ITER, FIN.
  - IDLE, start_i=1, single-cycle op: result is registered at the same edge. done_o=1 in the following cycle. State stays IDLE, so back-to-back starts are accepted every cycle.
  - IDLE, start_i=1, MUL/DIVU/REMU: operands latched, counter=0, go to ITER. busy_o=1 from the next cycle.
  - ITER: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle; counter increments. On counter==WIDTH-1 go to FIN.
  - FIN: result_o, zero_o registered; done_o=1 for exactly this cycle; busy_o=0; go to IDLE.
- Latency:
  - Single-cycle op started at edge N: done_o high during cycle N+1.
  - Iterative op started at edge N: done_o high during cycle N+WIDTH+1.
- start_i while busy_o=1 is ignored (not queued). ctrl_i/src*_i may change freely after acceptance.
- done_o is low in every cycle not listed above. result_o, zero_o and overflow_o keep their values between done pulses.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow_o = operand signs equal (ADD), or differ (SUB/1110), and the result sign differs from src1 sign.
  - MUL keeps the low WIDTH bits of the unsigned product; these are identical for signed operands.
  - Shift amount uses src1_i[SHW-1:0] only; upper bits are ignored.
  - SRA replicates src2_i[WIDTH-1].
- Divide by zero:
  - DIVU returns all ones; REMU returns src1.
  - Still takes the full WIDTH+1 latency; no exception is raised.
- Undefined codes: none; all 16 codes are defined.

Decomposition:
- Shared package seq_alu_pkg:
  - 4-bit opcode localparams (ALU_AND … ALU_SLTU), shared with the ALU control decoder.
  - FSM state encoding.
  - Helper function is_iterative(ctrl).
- One sub-module, seq_alu_iter: the shift-add/restoring-divide datapath.
  - Inputs: load, mode, operands.
  - Outputs: product/quotient/remainder registers.
  - Stepped by an enable from the FSM.
- Single-cycle ops stay as a combinational case in the top level.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x00000001 -> next cycle done_o=1, result_o=0x80000000, overflow_o=1, zero_o=0. SUB 5-5 -> result_o=0, zero_o=1. Code 1110 with 5,5 -> zero_o=0.
- SLT src1=0xFFFFFFFF, src2=1 -> result_o=1. SLTU with the same operands -> 0. SRA src1=4, src2=0x80000000 -> 0xF8000000. SRL with the same operands -> 0x08000000.
- MUL 7*6 started at edge N -> busy_o high for cycles N+1..N+32; done_o only at N+33; result_o=42. start_i pulses during busy are ignored; result is unchanged.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2, each after 33 cycles. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Drive rst_i low at cycle N+10 of a MUL -> immediately busy_o=0, result_o=0. No done_o follows. A fresh ADD 2+3 afterwards -> 5.
- Back-to-back single-cycle starts on 3 consecutive cycles (AND 0xF0&0x3C, OR, LUI src2=0x1234) -> three consecutive done_o pulses, results 0x30, 0xFC, 0x12340000.
